// File: rtl/tictactoe_pkg.sv
// Shared constants, FSM encoding and switch-decoding helpers for the move encoder.
package tictactoe_pkg;

    localparam logic [4:0] MOVE_IDLE  = 5'b01111;
    localparam logic [4:0] MOVE_CLEAR = 5'b00000;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        HOLD         = 2'd1,
        CLEAR        = 2'd2,
        WAIT_RELEASE = 2'd3
    } move_state_t;

    function automatic logic is_onehot(input logic [8:0] sel);
        return (sel != 9'd0) && ((sel & (sel - 9'd1)) == 9'd0);
    endfunction

    // Only meaningful for a one-hot select; positions are numbered 1..9.
    function automatic logic [3:0] onehot_to_pos(input logic [8:0] sel);
        logic [3:0] pos;
        pos = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (sel[i]) pos = 4'(i + 1);
        end
        return pos;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a saturating stability counter for one raw button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          sync_prev;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            sync_prev  <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
        end else begin
            sync_1    <= btn;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            if (sync_2 != sync_prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CW'(1);
            end
            // sync_prev has held its value for DEBOUNCE_CYCLES edges once the count tops out.
            if (stable_cnt == CNT_MAX) begin
                level <= sync_prev;
            end
        end
    end

endmodule

// File: rtl/move_encoder.sv
// Converts switch selection and debounced submit/clear buttons into timed move codes.
//
// state        | meaning
// IDLE         | waiting for a submit or clear event; move shows the no-op code
// HOLD         | driving {turn, position} for HOLD_CYCLES cycles
// CLEAR        | driving the clear code for HOLD_CYCLES cycles
// WAIT_RELEASE | waiting for both debounced buttons to go low
module move_encoder
    import tictactoe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [8:0] sw,
    input  logic       btn_submit,
    input  logic       btn_clear,
    input  logic [8:0] occupied,
    output logic [4:0] move,
    output logic       turn,
    output logic       busy,
    output logic       reject
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

    move_state_t    state, state_n;
    logic [4:0]     move_n;
    logic           turn_n;
    logic           reject_n;
    logic [HCW-1:0] hold_cnt, hold_cnt_n;

    logic submit_level, clear_level;
    logic submit_q, clear_q;
    logic submit_ev, clear_ev;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_submit (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_submit),
        .level   (submit_level)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_clear),
        .level   (clear_level)
    );

    assign submit_ev = submit_level & ~submit_q;
    assign clear_ev  = clear_level  & ~clear_q;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            move     <= MOVE_CLEAR;
            turn     <= PLAYER1;
            reject   <= 1'b0;
            hold_cnt <= '0;
            submit_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state    <= state_n;
            move     <= move_n;
            turn     <= turn_n;
            reject   <= reject_n;
            hold_cnt <= hold_cnt_n;
            submit_q <= submit_level;
            clear_q  <= clear_level;
        end
    end

    always_comb begin
        state_n    = state;
        move_n     = move;
        turn_n     = turn;
        reject_n   = 1'b0;
        hold_cnt_n = hold_cnt;
        case (state)
            IDLE: begin
                move_n = MOVE_IDLE;
                // Clear takes priority; a simultaneous submit is dropped silently.
                if (clear_ev) begin
                    state_n    = CLEAR;
                    move_n     = MOVE_CLEAR;
                    hold_cnt_n = HOLD_LOAD;
                end else if (submit_ev) begin
                    if (is_onehot(sw) && ((sw & occupied) == 9'd0)) begin
                        state_n    = HOLD;
                        move_n     = {turn, onehot_to_pos(sw)};
                        hold_cnt_n = HOLD_LOAD;
                    end else begin
                        state_n  = WAIT_RELEASE;
                        reject_n = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_n = WAIT_RELEASE;
                    move_n  = MOVE_IDLE;
                    turn_n  = (turn == PLAYER1) ? PLAYER2 : PLAYER1;
                end else begin
                    hold_cnt_n = hold_cnt - HCW'(1);
                end
            end
            CLEAR: begin
                if (hold_cnt == '0) begin
                    state_n = WAIT_RELEASE;
                    move_n  = MOVE_IDLE;
                    turn_n  = PLAYER1;
                end else begin
                    hold_cnt_n = hold_cnt - HCW'(1);
                end
            end
            WAIT_RELEASE: begin
                move_n = MOVE_IDLE;
                if (!submit_level && !clear_level) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                move_n  = MOVE_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_move_encoder.sv
// Self-checking bench for move_encoder: directed vector table, randomized operations, reset cases.
module tb_move_encoder;

    localparam int DEB  = 4;
    localparam int HOLD = 2;
    localparam logic [4:0] M_IDLE = 5'b01111;
    localparam logic [4:0] M_CLR  = 5'b00000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] sw = '0;
    logic [8:0] occupied = '0;
    logic       btn_submit = 1'b0;
    logic       btn_clear = 1'b0;
    logic [4:0] move;
    logic       turn;
    logic       busy;
    logic       reject;

    always #5 clk = ~clk;

    move_encoder #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw         (sw),
        .btn_submit (btn_submit),
        .btn_clear  (btn_clear),
        .occupied   (occupied),
        .move       (move),
        .turn       (turn),
        .busy       (busy),
        .reject     (reject)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: records every non-idle run on move (code, length) and every reject pulse length.
    bit         mon_en = 1'b0;
    logic [4:0] prev_move = 5'b01111;
    int         run_len = 0;
    int         rej_len = 0;
    logic [4:0] mv_code_q[$];
    int         mv_len_q[$];
    int         rej_q[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (move != prev_move) begin
                if (prev_move != M_IDLE) begin
                    mv_code_q.push_back(prev_move);
                    mv_len_q.push_back(run_len);
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_move = move;
            if (reject) begin
                rej_len++;
            end else if (rej_len > 0) begin
                rej_q.push_back(rej_len);
                rej_len = 0;
            end
        end else begin
            prev_move = M_IDLE;
            run_len   = 0;
            rej_len   = 0;
        end
    end

    task automatic run_op(input string name, input logic [8:0] s, input logic [8:0] o,
                          input bit sub, input bit clr, input int hold,
                          input int exp_mv, input logic [4:0] exp_code,
                          input int exp_rej, input logic exp_turn);
        int waited;
        mv_code_q.delete();
        mv_len_q.delete();
        rej_q.delete();
        @(posedge clk); #1;
        sw = s;
        occupied = o;
        btn_submit = sub;
        btn_clear = clr;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            // Disturb the inputs while a long press is being held to prove the code was latched.
            if (i == 7 && hold > 12) begin
                sw = 9'($urandom);
                occupied = 9'($urandom);
            end
        end
        btn_submit = 1'b0;
        btn_clear = 1'b0;
        repeat (20) @(posedge clk);
        waited = 0;
        while (busy && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        check({name, " busy_timeout"}, int'(busy), 0);
        repeat (3) @(negedge clk);
        check({name, " move_count"}, mv_code_q.size(), exp_mv);
        for (int k = 0; k < mv_code_q.size(); k++) begin
            check({name, " move_code"}, int'(mv_code_q[k]), int'(exp_code));
            check({name, " move_len"}, mv_len_q[k], HOLD);
        end
        check({name, " reject_count"}, rej_q.size(), exp_rej);
        for (int k = 0; k < rej_q.size(); k++) begin
            check({name, " reject_len"}, rej_q[k], 1);
        end
        check({name, " turn"}, int'(turn), int'(exp_turn));
    endtask

    // Reference model: outcome of one press from the game rules.
    task automatic model(input logic [8:0] s, input logic [8:0] o, input bit sub, input bit clr,
                         input int hold, inout logic t,
                         output int n_mv, output logic [4:0] code, output int n_rej);
        n_mv = 0;
        n_rej = 0;
        code = M_IDLE;
        if (hold < DEB || (!sub && !clr)) begin
            n_mv = 0;
        end else if (clr) begin
            n_mv = 1;
            code = M_CLR;
            t = 1'b0;
        end else if ($countones(s) == 1 && (s & o) == 9'd0) begin
            n_mv = 1;
            code = {t, 4'($clog2(s) + 1)};
            t = ~t;
        end else begin
            n_rej = 1;
        end
    endtask

    typedef struct {
        logic [8:0] sw;
        logic [8:0] occ;
        bit         sub;
        bit         clr;
        int         hold;
        int         exp_mv;
        logic [4:0] exp_code;
        int         exp_rej;
        logic       exp_turn;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       m_turn;
        logic [8:0] s, o;
        bit         sub, clr;
        int         hold, n_mv, n_rej, waited;
        logic [4:0] code;

        vecs.push_back('{9'b000010000, 9'b000000000, 1, 0, 10, 1, 5'b00101, 0, 1'b1});
        vecs.push_back('{9'b000000001, 9'b000000000, 1, 0, 10, 1, 5'b10001, 0, 1'b0});
        vecs.push_back('{9'b000000100, 9'b000000000, 1, 0, 12, 1, 5'b00011, 0, 1'b1});
        vecs.push_back('{9'b000010000, 9'b000010000, 1, 0, 10, 0, 5'b01111, 1, 1'b1});
        vecs.push_back('{9'b000000011, 9'b000010000, 1, 0, 10, 0, 5'b01111, 1, 1'b1});
        vecs.push_back('{9'b000000000, 9'b000000000, 1, 0, 10, 0, 5'b01111, 1, 1'b1});
        vecs.push_back('{9'b100000000, 9'b100000000, 1, 0, 10, 0, 5'b01111, 1, 1'b1});
        vecs.push_back('{9'b000001000, 9'b000000000, 1, 1, 10, 1, 5'b00000, 0, 1'b0});
        vecs.push_back('{9'b000000010, 9'b000000000, 1, 0,  3, 0, 5'b01111, 0, 1'b0});
        vecs.push_back('{9'b100000000, 9'b000000000, 1, 0, 50, 1, 5'b01001, 0, 1'b1});
        vecs.push_back('{9'b000001000, 9'b000000000, 1, 0, 10, 1, 5'b10100, 0, 1'b0});
        vecs.push_back('{9'b000000100, 9'b000000000, 1, 0, 10, 1, 5'b00011, 0, 1'b1});
        vecs.push_back('{9'b000000000, 9'b000000000, 0, 1, 10, 1, 5'b00000, 0, 1'b0});
        vecs.push_back('{9'b000000000, 9'b000000000, 1, 1, 10, 1, 5'b00000, 0, 1'b0});
        vecs.push_back('{9'b000000000, 9'b000000000, 0, 1,  2, 0, 5'b01111, 0, 1'b0});

        // Reset behaviour
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset move", int'(move), int'(M_CLR));
        check("reset turn", int'(turn), 0);
        check("reset busy", int'(busy), 0);
        check("reset reject", int'(reject), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset move", int'(move), int'(M_IDLE));
        mon_en = 1'b1;

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sw, vecs[i].occ, vecs[i].sub, vecs[i].clr,
                   vecs[i].hold, vecs[i].exp_mv, vecs[i].exp_code, vecs[i].exp_rej,
                   vecs[i].exp_turn);
        end

        // Randomized operations against the rule model
        m_turn = 1'b0;
        for (int i = 0; i < 25; i++) begin
            s = ($urandom_range(0, 1) == 1) ? (9'd1 << $urandom_range(0, 8)) : 9'($urandom);
            o = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom);
            clr = ($urandom_range(0, 5) == 0);
            sub = 1'b1;
            hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 20);
            model(s, o, sub, clr, hold, m_turn, n_mv, code, n_rej);
            run_op($sformatf("rnd%0d", i), s, o, sub, clr, hold, n_mv, code, n_rej, m_turn);
        end

        // Reset asserted in the middle of HOLD
        @(posedge clk); #1;
        sw = 9'b000000001;
        occupied = 9'd0;
        btn_submit = 1'b1;
        waited = 0;
        while (move == M_IDLE && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("abort hold_code", int'(move), int'({m_turn, 4'd1}));
        check("abort busy", int'(busy), 1);
        mon_en = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        btn_submit = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort reset move", int'(move), int'(M_CLR));
        check("abort reset turn", int'(turn), 0);
        check("abort reset busy", int'(busy), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort release move", int'(move), int'(M_IDLE));
        check("abort release turn", int'(turn), 0);
        repeat (30) @(negedge clk);
        check("abort settle move", int'(move), int'(M_IDLE));
        check("abort settle turn", int'(turn), 0);
        check("abort settle busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/move_encoder.md
MOVE_ENCODER -- requirements
Module: move_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of clocks a synchronized button level must be stable before it is accepted.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, the number of clocks a submitted or clear code is driven on move.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sw  input  9  position select switches; bit i selects board position i+1.
REQ-006 SHALL have port btn_submit  input  1  raw, asynchronous, bouncing submit button.
REQ-007 SHALL have port btn_clear  input  1  raw, asynchronous, bouncing clear button.
REQ-008 SHALL have port occupied  input  9  bit i is high when position i+1 is already owned, from the board store.
REQ-009 SHALL have port move  output  5  move code: bit 4 is the player (0 = player 1, 1 = player 2) and bits 3:0 are the position 1-9.
REQ-010 SHALL have port turn  output  1  player who submits next.
REQ-011 SHALL have port busy  output  1  high while the FSM is outside IDLE.
REQ-012 SHALL have port reject  output  1  one-cycle pulse when a submit is refused.

Function
REQ-013 SHALL pass each button through a 2-FF synchronizer, then a debouncer, and treat each rising edge of the debounced level as one event.
REQ-014 SHALL drive move = 5'b01111 (idle/no-op code) in IDLE and WAIT_RELEASE.
REQ-015 SHALL implement the FSM states IDLE, HOLD, CLEAR and WAIT_RELEASE.
REQ-016 On a submit event in IDLE, a submit SHALL be valid only when sw is exactly one-hot and occupied at that bit is 0.
REQ-017 On a valid submit, the block SHALL go to HOLD in the next cycle and drive move = {turn, i+1} for HOLD_CYCLES cycles, then toggle turn and go to WAIT_RELEASE.
REQ-018 On an invalid submit (zero-hot, multi-hot, or occupied position), the block SHALL pulse reject for 1 cycle, leave move and turn unchanged, and go to WAIT_RELEASE.
REQ-019 On a clear event in IDLE, the block SHALL go to CLEAR and drive move = 5'b00000 for HOLD_CYCLES cycles, set turn = 0, then go to WAIT_RELEASE.
REQ-020 If clear and submit events occur in the same cycle, clear SHALL win and the submit SHALL be discarded without a reject pulse.
REQ-021 Events arriving while in HOLD, CLEAR or WAIT_RELEASE SHALL be ignored.
REQ-022 WAIT_RELEASE SHALL return to IDLE only once both debounced buttons are low, so a held button produces exactly one event.
REQ-023 The debounce counter SHALL restart on any change of the synchronized level and SHALL saturate, never wrap.
REQ-024 The HOLD_CYCLES counter SHALL be sized by $clog2 and SHALL count exactly HOLD_CYCLES cycles.
REQ-025 sw and occupied SHALL be sampled in the cycle of the event; later changes SHALL NOT alter the code being held.

Reset
REQ-026 While reset_n is low at a clock edge, the block SHALL set move = 5'b00000 (so the board is cleared), turn = 0, busy = 0, reject = 0, FSM = IDLE, and all counters and debounced levels to 0.
REQ-027 In the first cycle after reset_n goes high, move SHALL be 5'b01111.
REQ-028 A reset asserted mid-HOLD or mid-CLEAR SHALL abort the operation with no toggle of turn.

Structure
REQ-029 Package tictactoe_pkg SHALL hold MOVE_IDLE (5'b01111), MOVE_CLEAR (5'b00000), the PLAYER1/PLAYER2 constants and the FSM state encoding.
REQ-030 Sub-module btn_debounce (synchronizer plus counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.

Verification (bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=2)
REQ-031 Reset: hold reset_n low for 3 cycles -> move=00000, turn=0, busy=0; 1 cycle after release -> move=01111.
REQ-032 sw=9'b000010000, occupied=0, btn_submit held high for 10 cycles -> move=00101 for exactly 2 cycles, then 01111, turn=1; then sw=9'b000000001 with a second press -> move=10001, turn=0.
REQ-033 occupied[4]=1, sw=9'b000010000, submit -> reject high for 1 cycle, move stays 01111, turn unchanged; repeat with sw=9'b000000011 -> same response.
REQ-034 btn_submit and btn_clear rise in the same cycle -> move=00000 for 2 cycles, turn=0, no reject.
REQ-035 btn_submit glitches high for 3 cycles then low, and separately is held high for 50 cycles -> no move for the glitch, exactly one move for the hold.
REQ-036 reset_n pulsed low during HOLD -> move=00000 during reset, then 01111, turn=0.
